rx_serial_deserializer: RTL and testbench

//  Serial-to-parallel front end of the RX path. Samples serial line data_in once per clk_32f, MSB first.

---
 rtl/rx_pkg.sv | 6 +
 rtl/rx_serial_deserializer.sv | 99 +++++++++
 tb/tb_rx_serial_deserializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared RX symbols and deserializer state encoding
package rx_pkg;
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2} rx_state_t;
endpackage

// File: rtl/rx_serial_deserializer.sv
// rx_serial_deserializer: MSB-first serial-to-byte front end with COM alignment and lock
// Optional valid-byte counter on byte_cnt when RX_BYTE_CNT_EN is defined.
module rx_serial_deserializer
  import rx_pkg::*;
#(
  parameter int COM_COUNT = 4,
  parameter logic [7:0] COM_SYM = COM_SYM_DEF
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active_out
`ifdef RX_BYTE_CNT_EN
  ,output logic [15:0] byte_cnt
`endif
);
  localparam logic [3:0] CC = 4'(COM_COUNT);
  rx_state_t state, state_n;
  logic [7:0] shift, nxt, data_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] com_cnt, com_cnt_n, com_inc;
  logic is_com, last, valid_n, strobe_n, active_n;
`ifdef RX_BYTE_CNT_EN
  logic [15:0] cnt_n;
`endif
  always_comb begin
    nxt = {shift[6:0], data_in};
    is_com = nxt == COM_SYM;
    last = bit_cnt == 3'd7;
    com_inc = com_cnt == 4'hF ? 4'hF : com_cnt + 4'd1;
    state_n = state;
    bit_cnt_n = bit_cnt + 3'd1;
    com_cnt_n = com_cnt;
    data_n = data_out;
    valid_n = valid_out;
    strobe_n = 1'b0;
    active_n = active_out;
`ifdef RX_BYTE_CNT_EN
    cnt_n = byte_cnt;
`endif
    case (state)
      SEARCH: if (is_com) begin
        bit_cnt_n = 3'd0;
        com_cnt_n = 4'd1;
        state_n = CC == 4'd1 ? ACTIVE : ALIGN;
        active_n = CC == 4'd1;
      end
      ALIGN: begin
        strobe_n = last;
        if (last) begin
          com_cnt_n = is_com ? com_inc : 4'd0;
          state_n = !is_com ? SEARCH : com_inc >= CC ? ACTIVE : ALIGN;
          active_n = is_com && com_inc >= CC;
        end
      end
      ACTIVE: begin
        strobe_n = last;
        if (last) begin
          data_n = nxt;
          valid_n = !is_com;
`ifdef RX_BYTE_CNT_EN
          cnt_n = !is_com && byte_cnt != 16'hFFFF ? byte_cnt + 16'd1 : byte_cnt;
`endif
        end
      end
      default: state_n = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state <= SEARCH;
      shift <= 8'd0;
      bit_cnt <= 3'd0;
      com_cnt <= 4'd0;
      data_out <= 8'd0;
      valid_out <= 1'b0;
      byte_strobe <= 1'b0;
      active_out <= 1'b0;
`ifdef RX_BYTE_CNT_EN
      byte_cnt <= 16'd0;
`endif
    end else begin
      state <= state_n;
      shift <= nxt;
      bit_cnt <= bit_cnt_n;
      com_cnt <= com_cnt_n;
      data_out <= data_n;
      valid_out <= valid_n;
      byte_strobe <= strobe_n;
      active_out <= active_n;
`ifdef RX_BYTE_CNT_EN
      byte_cnt <= cnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_rx_serial_deserializer.sv
// tb_rx_serial_deserializer: random and directed stimulus against a byte-level reference model
module tb_rx_serial_deserializer;
  localparam int N = 4;
  localparam logic [7:0] COM = 8'hBC;
  logic clk_32f = 1'b0, reset_L = 1'b0, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, byte_strobe, active_out;
`ifdef RX_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif
  int n_chk = 0, n_err = 0;
  logic [7:0] m_hist, m_data;
  int m_mode, m_pos, m_coms, m_cnt;
  logic m_valid, m_strobe, m_active;

  rx_serial_deserializer dut (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in), .data_out(data_out),
    .valid_out(valid_out), .byte_strobe(byte_strobe), .active_out(active_out)
`ifdef RX_BYTE_CNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hist = 0; m_data = 0; m_mode = 0; m_pos = 0; m_coms = 0; m_cnt = 0;
    m_valid = 0; m_strobe = 0; m_active = 0;
  endtask

  // mode 0 = hunting bitwise, 1 = counting aligned COMs, 2 = locked
  task automatic m_step(input logic b);
    m_hist = {m_hist[6:0], b};
    m_strobe = 0;
    if (m_mode == 0) begin
      if (m_hist == COM) begin
        m_pos = 0; m_coms = 1;
        if (N == 1) begin m_mode = 2; m_active = 1; end else m_mode = 1;
      end
    end else begin
      m_pos++;
      if (m_pos == 8) begin
        m_pos = 0;
        m_strobe = 1;
        if (m_mode == 1) begin
          if (m_hist == COM) begin
            m_coms++;
            if (m_coms >= N) begin m_mode = 2; m_active = 1; end
          end else begin
            m_mode = 0; m_coms = 0;
          end
        end else begin
          m_data = m_hist;
          m_valid = m_hist != COM;
          if (m_valid && m_cnt < 65535) m_cnt++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("data_out", {8'd0, data_out}, {8'd0, m_data});
    chk("valid_out", {15'd0, valid_out}, {15'd0, m_valid});
    chk("byte_strobe", {15'd0, byte_strobe}, {15'd0, m_strobe});
    chk("active_out", {15'd0, active_out}, {15'd0, m_active});
`ifdef RX_BYTE_CNT_EN
    chk("byte_cnt", byte_cnt, 16'(m_cnt));
`endif
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    m_step(b);
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    reset_L = 0;
    m_reset();
    #1;
    compare_all();
    for (int i = 0; i < 3; i++) begin
      data_in = ~data_in;
      @(posedge clk_32f);
      #1;
      compare_all();
    end
    reset_L = 1;
  endtask

  initial begin
    m_reset();
    #1;
    do_reset();
    repeat (4) send_byte(COM);
    chk("lock_after_4_com", {15'd0, active_out}, 16'd1);
    send_byte(8'hAB);
    chk("first_data", {8'd0, data_out}, 16'h00AB);
    chk("first_valid", {15'd0, valid_out}, 16'd1);
    do_reset();
    send_bit(1); send_bit(1); send_bit(0);
    repeat (3) send_byte(COM);
    send_byte(8'h00);
    chk("no_lock_after_break", {15'd0, active_out}, 16'd0);
    repeat (4) send_byte(COM);
    chk("lock_second_run", {15'd0, active_out}, 16'd1);
    chk("valid_idle", {15'd0, valid_out}, 16'd0);
    send_byte(8'hBC); send_byte(8'hBD); send_byte(8'hBA); send_byte(8'hAB);
    chk("stream_last", {8'd0, data_out}, 16'h00AB);
    send_bit(1); send_bit(0); send_bit(1);
    #3 reset_L = 0;
    m_reset();
    #1;
    chk("async_active_drop", {15'd0, active_out}, 16'd0);
    chk("async_valid_drop", {15'd0, valid_out}, 16'd0);
    do_reset();
    repeat (3) send_byte(COM);
    chk("relock_needs_4", {15'd0, active_out}, 16'd0);
    send_byte(COM);
    chk("relock_4th", {15'd0, active_out}, 16'd1);
    do_reset();
    repeat (4) send_byte(COM);
    repeat (10) send_byte(8'hAB);
    repeat (2) send_byte(COM);
`ifdef RX_BYTE_CNT_EN
    chk("byte_cnt_10", byte_cnt, 16'd10);
`endif
    chk("cnt_run_idle", {15'd0, valid_out}, 16'd0);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 12)) begin
        if ($urandom_range(0, 1) == 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
